// File: rtl/tick_stopwatch.sv
// tick_stopwatch: 00.0 .. 99.9 s BCD stopwatch with start/stop, clear and pause blink.
// Every external input is synchronized and edge-detected into a single-cycle tick.
// All outputs come straight from registers.
module tick_stopwatch #(
    parameter int HOLD_AT_MAX = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       slow_clk,
    input  logic       fast_clk,
    input  logic       btn_start,
    input  logic       btn_clear,
    output logic [3:0] tenths,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       running,
    output logic       overflow,
    output logic       blink
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        FULL  = 2'd3
    } state_t;

    // Bit order of the input vectors: 0 slow, 1 fast, 2 start, 3 clear.
    logic [3:0] w_async;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] r_prev;
    logic [3:0] r_armed;
    logic [1:0] r_vld;
    logic [3:0] w_tick;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_tenths, r_ones, r_tens;
    logic [3:0] w_tenths_next, w_ones_next, w_tens_next;
    logic       r_running, r_overflow, r_blink;
    logic       w_ovf_next, w_blink_next;
    logic       w_at_max;
    logic [11:0] w_inc;

    // Ripple-carry BCD increment of {tens, ones, tenths}; wraps 99.9 -> 00.0.
    function automatic logic [11:0] bcd_inc(input logic [11:0] d);
        logic [3:0] t, o, n;
        t = d[11:8];
        o = d[7:4];
        n = d[3:0];
        if (n == 4'd9) begin
            n = 4'd0;
            if (o == 4'd9) begin
                o = 4'd0;
                t = (t == 4'd9) ? 4'd0 : t + 4'd1;
            end else begin
                o = o + 4'd1;
            end
        end else begin
            n = n + 4'd1;
        end
        return {t, o, n};
    endfunction

    assign w_async = {btn_clear, btn_start, fast_clk, slow_clk};

    // Input synchronizers and edge detectors. r_vld marks when r_sync2 holds a
    // real sample after reset; an input must be seen low before it can tick, so
    // a level already high at reset release never produces a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_armed <= '0;
            r_vld   <= '0;
        end else begin
            r_sync1 <= w_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_vld   <= {r_vld[0], 1'b1};
            r_armed <= r_armed | (~r_sync2 & {4{r_vld[1]}});
        end
    end

    assign w_tick   = r_sync2 & ~r_prev & r_armed;
    assign w_at_max = (r_tens == 4'd9) && (r_ones == 4'd9) && (r_tenths == 4'd9);
    assign w_inc    = bcd_inc({r_tens, r_ones, r_tenths});

    // Next-state, next-digit and next-flag logic; priority is clear > start > slow.
    always_comb begin
        w_state_next  = r_state;
        w_tenths_next = r_tenths;
        w_ones_next   = r_ones;
        w_tens_next   = r_tens;
        w_ovf_next    = (r_state == FULL);
        w_blink_next  = r_blink;
        case (r_state)
            IDLE: begin
                if (w_tick[3]) begin
                    {w_tens_next, w_ones_next, w_tenths_next} = 12'h000;
                end else if (w_tick[2]) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_tick[3]) begin
                    w_state_next = IDLE;
                    {w_tens_next, w_ones_next, w_tenths_next} = 12'h000;
                end else if (w_tick[2]) begin
                    w_state_next = PAUSE;
                end else if (w_tick[0]) begin
                    if (w_at_max) begin
                        w_ovf_next = 1'b1;
                        if (HOLD_AT_MAX != 0) begin
                            w_state_next = FULL;
                        end else begin
                            {w_tens_next, w_ones_next, w_tenths_next} = 12'h000;
                        end
                    end else begin
                        {w_tens_next, w_ones_next, w_tenths_next} = w_inc;
                    end
                end
            end
            PAUSE: begin
                if (w_tick[3]) begin
                    w_state_next = IDLE;
                    {w_tens_next, w_ones_next, w_tenths_next} = 12'h000;
                end else if (w_tick[2]) begin
                    w_state_next = RUN;
                end else if (w_tick[1]) begin
                    w_blink_next = ~r_blink;
                end
            end
            FULL: begin
                if (w_tick[3]) begin
                    w_state_next = IDLE;
                    w_ovf_next   = 1'b0;
                    {w_tens_next, w_ones_next, w_tenths_next} = 12'h000;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (w_state_next != PAUSE) begin
            w_blink_next = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Registered digits and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tenths   <= 4'd0;
            r_ones     <= 4'd0;
            r_tens     <= 4'd0;
            r_running  <= 1'b0;
            r_overflow <= 1'b0;
            r_blink    <= 1'b0;
        end else begin
            r_tenths   <= w_tenths_next;
            r_ones     <= w_ones_next;
            r_tens     <= w_tens_next;
            r_running  <= (w_state_next == RUN);
            r_overflow <= w_ovf_next;
            r_blink    <= w_blink_next;
        end
    end

    assign tenths   = r_tenths;
    assign ones     = r_ones;
    assign tens     = r_tens;
    assign running  = r_running;
    assign overflow = r_overflow;
    assign blink    = r_blink;

endmodule

// File: doc/tick_stopwatch.md
TICK_STOPWATCH -- requirements
Module: tick_stopwatch

Interface
REQ-001 Parameter: HOLD_AT_MAX, default 1; 1 = saturate at 99.9 s, 0 = wrap to 00.0.
REQ-002 Port: clk  input  1  system clock, 100 MHz; all state updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: slow_clk  input  1  divided clock, one rising edge per 0.1 s; asynchronous to internal logic for sampling purposes.
REQ-005 Port: fast_clk  input  1  faster divided clock; rising edges drive the pause blink.
REQ-006 Port: btn_start  input  1  start/stop request, debounced level; each rising edge is one request.
REQ-007 Port: btn_clear  input  1  clear request, debounced level; each rising edge is one request.
REQ-008 Port: tenths  output  4  BCD tenths-of-second digit.
REQ-009 Port: ones  output  4  BCD seconds digit.
REQ-010 Port: tens  output  4  BCD tens-of-seconds digit.
REQ-011 Port: running  output  1  high only in state RUN.
REQ-012 Port: overflow  output  1  count-limit indicator; see REQ-022 and REQ-023.
REQ-013 Port: blink  output  1  display blink control; toggles only in state PAUSE.

Function
REQ-014 slow_clk, fast_clk, btn_start and btn_clear SHALL each pass through a 2-flop synchronizer, followed by a previous-value flop.
REQ-015 Each synchronized input SHALL produce a tick = sync2 AND NOT prev.
  - Tick is high exactly one clk cycle per input rising edge.
  - Tick is high in the second clk cycle after the first clk edge that samples the input high.
REQ-016 FSM states SHALL be IDLE, RUN, PAUSE and FULL, with IDLE as the reset state.
REQ-017 IDLE transitions SHALL be: start tick -> RUN; clear tick -> IDLE, with digits held at 00.0.
REQ-018 RUN transitions SHALL be: start tick -> PAUSE; clear tick -> IDLE, with digits zeroed; slow tick -> count +0.1.
REQ-019 PAUSE transitions SHALL be: start tick -> RUN; clear tick -> IDLE, with digits zeroed; slow ticks ignored.
REQ-020 FULL transitions SHALL be: clear tick -> IDLE, with digits zeroed and overflow cleared; start and slow ticks ignored.
REQ-021 Counting SHALL be a BCD cascade.
  - tenths 9 -> 0 carries into ones.
  - ones 9 -> 0 carries into tens.
  - No digit ever holds a value above 9.
REQ-022 With HOLD_AT_MAX=1, a slow tick at 99.9 in RUN SHALL:
  - keep the digits at 99.9;
  - move the FSM to FULL;
  - set overflow high until clear or reset.
REQ-023 With HOLD_AT_MAX=0, a slow tick at 99.9 in RUN SHALL:
  - set the digits to 00.0;
  - stay in RUN;
  - pulse overflow high for exactly one cycle.
  - FULL is then unreachable.
REQ-024 Simultaneous ticks in one cycle SHALL be prioritized clear > start > slow.
  - Only the highest-priority action takes effect.
  - A start tick in the same cycle as a slow tick in RUN pauses without incrementing.
REQ-025 Digit updates SHALL take effect on the clk edge that ends the tick cycle: one cycle of latency from tick to output.
REQ-026 blink SHALL:
  - be forced to 0 in every state other than PAUSE;
  - be 0 on entry to PAUSE;
  - invert on each fast tick while in PAUSE.
REQ-027 running SHALL be a registered decode of the FSM state, and outputs SHALL never be driven from combinational tick logic.

Reset
REQ-028 Asserting rst at any time, including mid-count, SHALL immediately clear all of the following:
  - synchronizer and prev flops;
  - the FSM, forced to IDLE;
  - tenths, ones and tens, forced to 0;
  - running, overflow and blink, forced to 0.
REQ-029 After rst deasserts, no tick SHALL be generated for an input that is already high; a fresh rising edge is required.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
  - Reset, start edge, 25 slow edges -> running=1, digits 02.5; increments one cycle after each slow tick.
  - Start edge at 04.7, then 10 slow edges -> running=0, digits stay 04.7; blink toggles on each fast edge; second start -> RUN, blink=0.
  - HOLD_AT_MAX=1 at 99.9, slow edge -> state FULL, digits 99.9, overflow=1; start ignored; clear edge -> 00.0, overflow=0, IDLE.
  - HOLD_AT_MAX=0 at 99.9, slow edge -> 00.0, overflow high exactly 1 cycle, running=1.
  - Clear, start and slow edges aligned to the same cycle in RUN at 12.3 -> 00.0, IDLE; start and slow aligned -> PAUSE at 12.3.
  - rst asserted mid-count at 37.6 -> all outputs 0 asynchronously; release with btn_start held high -> stays IDLE.
